// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 hex keypad scanner: FSM states, idle column
// drive and the (row,col) -> hex code map.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_PEND,
    HELD,
    RELEASE_PEND
  } state_t;

  localparam logic [3:0] COL_IDLE = 4'b1110;

  // Indexed by 4*row + col; entry 0 is (r0,c0).
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_code(input logic [3:0] idx);
    return KEY_MAP[idx];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (keypad rows, switches,
// buttons) with a configurable reset value.
module sync_2ff #(
  parameter int              WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 hex keypad, debounces over whole scans and shifts each accepted
// key into a 16-bit value/set pair suitable for the 7-segment display driver.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_BIT       = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        clear,
  output logic [3:0]  col,
  output logic [3:0]  key,
  output logic        key_valid,
  output logic        key_down,
  output logic [15:0] value,
  output logic        set
);

  localparam int CNT_W = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]          row_sync;
  logic [SCAN_BIT+1:0] scan_cnt;
  logic [1:0]          col_sel;
  logic                last_dwell;
  logic                scan_done;
  logic [15:0]         scan_map;
  logic [15:0]         map_next;
  logic [4:0]          hit_count;
  logic [3:0]          hit_idx;
  logic                single;
  logic                none;
  logic [3:0]          cand_code;
  state_t              state;
  logic [3:0]          pend_code;
  logic [CNT_W-1:0]    stab_cnt;
  logic [CNT_W-1:0]    stab_inc;
  logic                accept;
  logic                release_done;

  sync_2ff #(
    .WIDTH       (4),
    .RESET_VALUE (4'b1111)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_sync)
  );

  assign col_sel    = scan_cnt[SCAN_BIT+1:SCAN_BIT];
  assign last_dwell = &scan_cnt[SCAN_BIT-1:0];
  assign scan_done  = last_dwell && (col_sel == 2'd3);
  assign col        = ~(4'b0001 << col_sel);

  // The current column's sample is merged in so a scan result includes column 3.
  always_comb begin
    map_next = scan_map;
    for (int r = 0; r < 4; r++) begin
      map_next[4*r + int'(col_sel)] = ~row_sync[r];
    end
  end

  always_comb begin
    hit_count = '0;
    hit_idx   = '0;
    for (int i = 0; i < 16; i++) begin
      if (map_next[i]) begin
        hit_count = hit_count + 5'd1;
        hit_idx   = 4'(i);
      end
    end
  end

  assign single    = (hit_count == 5'd1);
  assign none      = (hit_count == 5'd0);
  assign cand_code = key_code(hit_idx);
  assign stab_inc  = stab_cnt + CNT_ONE;

  assign accept = scan_done && single &&
                  (((state == IDLE) && (DEBOUNCE_SCANS == 1)) ||
                   ((state == PRESS_PEND) && (cand_code == pend_code) && (stab_inc == DEB_CNT)));

  assign release_done = scan_done && none &&
                        (((state == HELD) && (DEBOUNCE_SCANS == 1)) ||
                         ((state == RELEASE_PEND) && (stab_inc == DEB_CNT)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_map <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (last_dwell) scan_map <= map_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pend_code <= '0;
      stab_cnt  <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (accept) begin
        state     <= HELD;
        key       <= cand_code;
        key_valid <= 1'b1;
        key_down  <= 1'b1;
      end else if (release_done) begin
        state    <= IDLE;
        key_down <= 1'b0;
      end else if (scan_done) begin
        case (state)
          IDLE: begin
            if (single) begin
              state     <= PRESS_PEND;
              pend_code <= cand_code;
              stab_cnt  <= CNT_ONE;
            end
          end
          PRESS_PEND: begin
            if (!single) begin
              state <= IDLE;
            end else if (cand_code != pend_code) begin
              pend_code <= cand_code;
              stab_cnt  <= CNT_ONE;
            end else begin
              stab_cnt <= stab_inc;
            end
          end
          HELD: begin
            if (none) begin
              state    <= RELEASE_PEND;
              stab_cnt <= CNT_ONE;
            end
          end
          RELEASE_PEND: begin
            if (!none) state <= HELD;
            else       stab_cnt <= stab_inc;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Clear beats a simultaneous key acceptance; the oldest digit falls off the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      set   <= 1'b0;
    end else if (clear) begin
      value <= '0;
      set   <= 1'b1;
    end else if (accept) begin
      value <= {value[11:0], cand_code};
      set   <= 1'b1;
    end else begin
      set <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad: a pressed key
// (r,c) pulls row r low while column c is driven low.
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic        clear;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_down;
  logic [15:0] value;
  logic        set;

  logic [15:0] pressed;

  int total;
  int bad;
  int kv_count;
  int set_count;
  logic [3:0]  kv_key;
  logic [15:0] kv_value;
  logic        kv_set;

  keypad_scanner #(
    .SCAN_BIT       (2),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .clear     (clear),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_down  (key_down),
    .value     (value),
    .set       (set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[4*r + c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input logic clr);
    pressed = keys;
    clear   = clr;
  endtask

  task automatic clearCounts();
    kv_count  = 0;
    set_count = 0;
    kv_key    = '0;
    kv_value  = '0;
    kv_set    = 1'b0;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (set) set_count++;
      if (key_valid) begin
        kv_count++;
        kv_key   = key;
        kv_value = value;
        kv_set   = set;
      end
    end
  endtask

  logic [15:0] entry_keys [5];
  logic [15:0] entry_vals [5];
  logic [3:0]  entry_code [5];

  initial begin
    total = 0;
    bad   = 0;
    entry_keys = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0020};
    entry_vals = '{16'h0001, 16'h0012, 16'h0123, 16'h123A, 16'h23A5};
    entry_code = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h5};
    clearCounts();

    rst = 1'b1;
    applyStimulus(16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    runCycles(6);
    checkOutput("col_scanning", 16'(col), 16'h000D);

    // asynchronous reset asserted mid-cycle
    #3 rst = 1'b1;
    #1;
    checkOutput("reset_col", 16'(col), 16'h000E);
    checkOutput("reset_value", value, 16'h0000);
    checkOutput("reset_key_valid", 16'(key_valid), 16'h0000);
    checkOutput("reset_key_down", 16'(key_down), 16'h0000);
    checkOutput("reset_set", 16'(set), 16'h0000);
    @(posedge clk);
    #1 rst = 1'b0;

    // single press of key 6 at (r1,c2)
    clearCounts();
    applyStimulus(16'h0040, 1'b0);
    runCycles(80);
    checkOutput("press6_pulses", 16'(kv_count), 16'd1);
    checkOutput("press6_key", 16'(kv_key), 16'h0006);
    checkOutput("press6_value", kv_value, 16'h0006);
    checkOutput("press6_set_same_cycle", 16'(kv_set), 16'h0001);
    checkOutput("press6_set_pulses", 16'(set_count), 16'd1);
    checkOutput("press6_key_down", 16'(key_down), 16'h0001);
    clearCounts();
    applyStimulus(16'h0000, 1'b0);
    runCycles(32);
    checkOutput("release6_still_down", 16'(key_down), 16'h0001);
    runCycles(48);
    checkOutput("release6_key_down", 16'(key_down), 16'h0000);
    checkOutput("release6_no_pulse", 16'(kv_count), 16'd0);

    // bounce on key 1 at (r0,c0), then steady hold
    clearCounts();
    for (int t = 0; t < 5; t++) begin
      applyStimulus((t % 2 == 0) ? 16'h0001 : 16'h0000, 1'b0);
      runCycles(20);
    end
    checkOutput("bounce_no_pulse", 16'(kv_count), 16'd0);
    runCycles(80);
    checkOutput("bounce_pulses", 16'(kv_count), 16'd1);
    checkOutput("bounce_key", 16'(kv_key), 16'h0001);
    checkOutput("bounce_value", kv_value, 16'h0061);
    applyStimulus(16'h0000, 1'b0);
    runCycles(80);
    checkOutput("bounce_released", 16'(key_down), 16'h0000);

    // clear, then enter 1 2 3 A 5
    applyStimulus(16'h0000, 1'b1);
    runCycles(1);
    checkOutput("clear_value", value, 16'h0000);
    checkOutput("clear_set", 16'(set), 16'h0001);
    applyStimulus(16'h0000, 1'b0);
    runCycles(1);
    checkOutput("clear_set_one_cycle", 16'(set), 16'h0000);
    clearCounts();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(entry_keys[k], 1'b0);
      runCycles(80);
      checkOutput($sformatf("entry%0d_key", k), 16'(kv_key), 16'(entry_code[k]));
      checkOutput($sformatf("entry%0d_value", k), value, entry_vals[k]);
      applyStimulus(16'h0000, 1'b0);
      runCycles(80);
    end
    checkOutput("entry_set_pulses", 16'(set_count), 16'd5);
    checkOutput("entry_valid_pulses", 16'(kv_count), 16'd5);

    // two keys together from idle
    clearCounts();
    applyStimulus(16'h8001, 1'b0);
    runCycles(80);
    checkOutput("multi_no_pulse", 16'(kv_count), 16'd0);
    checkOutput("multi_key_down", 16'(key_down), 16'h0000);
    applyStimulus(16'h0000, 1'b0);
    runCycles(80);

    // hold key 0, then add D while held
    clearCounts();
    applyStimulus(16'h1000, 1'b0);
    runCycles(80);
    checkOutput("hold0_pulses", 16'(kv_count), 16'd1);
    checkOutput("hold0_key", 16'(kv_key), 16'h0000);
    checkOutput("hold0_value", value, 16'h3A50);
    clearCounts();
    applyStimulus(16'h9000, 1'b0);
    runCycles(80);
    checkOutput("addD_no_pulse", 16'(kv_count), 16'd0);
    checkOutput("addD_key_down", 16'(key_down), 16'h0001);
    checkOutput("addD_value", value, 16'h3A50);
    applyStimulus(16'h0000, 1'b0);
    runCycles(80);
    checkOutput("hold0_released", 16'(key_down), 16'h0000);

    // clear held across acceptance of F at (r3,c1)
    clearCounts();
    applyStimulus(16'h2000, 1'b1);
    runCycles(80);
    checkOutput("clrF_pulses", 16'(kv_count), 16'd1);
    checkOutput("clrF_key", 16'(kv_key), 16'h000F);
    checkOutput("clrF_value", kv_value, 16'h0000);
    checkOutput("clrF_set", 16'(kv_set), 16'h0001);
    applyStimulus(16'h2000, 1'b0);
    runCycles(2);
    applyStimulus(16'h0000, 1'b0);
    runCycles(80);
    clearCounts();
    applyStimulus(16'h0100, 1'b0);
    runCycles(80);
    checkOutput("press7_key", 16'(kv_key), 16'h0007);
    checkOutput("press7_value", value, 16'h0007);

    // reset while 7 is still held, then re-acceptance
    #3 rst = 1'b1;
    #1;
    checkOutput("midpress_reset_value", value, 16'h0000);
    checkOutput("midpress_reset_key_down", 16'(key_down), 16'h0000);
    checkOutput("midpress_reset_col", 16'(col), 16'h000E);
    @(posedge clk);
    #1 rst = 1'b0;
    clearCounts();
    runCycles(80);
    checkOutput("reaccept_pulses", 16'(kv_count), 16'd1);
    checkOutput("reaccept_key", 16'(kv_key), 16'h0007);
    checkOutput("reaccept_value", value, 16'h0007);
    applyStimulus(16'h0000, 1'b0);
    runCycles(80);
    checkOutput("final_released", 16'(key_down), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
